muldiv_unit: RTL

- Parametrised iterative multiply/divide unit for the EX stage, successor to the combinational-launch ALU mul/div path.
- Owns the architectural HI/LO registers.
- Uses a start/busy/done handshake and supports a pipeline flush that aborts an in-flight operation.
- Handles MULT, MULTU, DIV, DIVU, MUL (low word to GPR), MTHI and MTLO.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Start/busy/done handshake bundle between the EX stage and the mul/div unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply / restoring radix-2 divide unit owning the architectural HI/LO pair.
// Operands are captured at acceptance; the multiplier result is taken in the last MUL cycle.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic    clk_i,
    input  logic    rst_i,
    muldiv_if.slave bus
);

    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // IDLE: ready | MUL: latency countdown | DIV_PRE: magnitudes | DIV_ITER: one bit/cycle | DIV_POST: signs
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PRE,
        S_DIV_ITER,
        S_DIV_POST
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               is_mul_op, is_div_op;
    logic               sgn_op, a_neg, b_neg, b_zero, cnt_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH:0]     shifted, diff;
    logic               fits;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
    assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || (bus.op == OP_MUL);
    assign is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

    assign sgn_op   = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign a_neg    = sgn_op & a_q[WIDTH-1];
    assign b_neg    = sgn_op & b_q[WIDTH-1];
    assign a_mag    = a_neg ? -a_q : a_q;
    assign b_mag    = b_neg ? -b_q : b_q;
    assign b_zero   = (b_q == '0);
    assign cnt_zero = (cnt_q == '0);

    assign prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    assign prod     = (a_neg ^ b_neg) ? -prod_mag : prod_mag;

    // Borrow out of the trial subtraction means the divisor did not fit.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = !diff[WIDTH];

    assign quo_fin = (a_neg ^ b_neg) ? -quo_q : quo_q;
    assign rem_fin = a_neg ? -rem_q : rem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul_op) begin
                    state_d = S_MUL;
                end else if (accept && is_div_op) begin
                    state_d = S_DIV_PRE;
                end
            end
            S_MUL: begin
                if (bus.flush || cnt_zero) begin
                    state_d = S_IDLE;
                end
            end
            S_DIV_PRE: begin
                state_d = bus.flush ? S_IDLE : S_DIV_ITER;
            end
            S_DIV_ITER: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_zero) begin
                    state_d = S_DIV_POST;
                end
            end
            S_DIV_POST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = '0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (bus.op == OP_MTHI)) hi_d = bus.a;
                if (accept && (bus.op == OP_MTLO)) lo_d = bus.a;
            end
            S_MUL: begin
                if (!bus.flush && cnt_zero) begin
                    done_d = 1'b1;
                    if (op_q == OP_MUL) begin
                        result_d = prod[WIDTH-1:0];
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            S_DIV_POST: begin
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (b_zero) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fin;
                        lo_d = quo_fin;
                    end
                end
            end
            default: begin
            end
        endcase
        // Busy appears from the second in-flight cycle and drops with the done edge.
        busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            if (accept) begin
                op_q  <= bus.op;
                a_q   <= bus.a;
                b_q   <= bus.b;
                cnt_q <= CNT_W'(MUL_LATENCY - 1);
            end
            case (state_q)
                S_MUL: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_DIV_PRE: begin
                    rem_q <= '0;
                    quo_q <= a_mag;
                    dvs_q <= b_mag;
                    cnt_q <= CNT_W'(WIDTH - 1);
                end
                S_DIV_ITER: begin
                    rem_q <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], fits};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

endmodule
